// File: rtl/sync_event_arbiter.sv
// Rising-edge event queue per sync/status line with round-robin delivery on one valid/ready port.
// Optional input synchronizer: define SEV_INPUT_SYNC_EN.
module sync_event_arbiter #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  signal_in,
   input  logic [N_CH-1:0]  ch_enable,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [IDX_W-1:0] ev_ch,
   output logic [N_CH-1:0]  overflow,
   input  logic [N_CH-1:0]  overflow_clr,
   output logic             pending_any
);

   localparam logic             ST_IDLE    = 1'b0;
   localparam logic             ST_PRESENT = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic [N_CH-1:0]  w_sig;
   logic [N_CH-1:0]  r_sig_d;
   logic [N_CH-1:0]  w_rise;
   logic [N_CH-1:0]  w_pend;
   logic [N_CH-1:0]  w_dec;
   logic [N_CH-1:0]  w_ovf_set;
   logic [CNT_W-1:0] r_cnt [N_CH];
   logic [N_CH-1:0]  r_ovf;
   logic             r_state;
   logic             r_ev_valid;
   logic [IDX_W-1:0] r_ev_ch;
   logic [IDX_W-1:0] r_rr;
   logic             w_hs;
   logic             w_found;
   logic [IDX_W-1:0] w_grant;
   int               w_dist;
   int               w_best;

`ifdef SEV_INPUT_SYNC_EN
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;

   // Both stages load the raw input during reset so a line already high stays silent.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= signal_in;
         r_sync2 <= signal_in;
      end else begin
         r_sync1 <= signal_in;
         r_sync2 <= r_sync1;
      end
   end
   assign w_sig = r_sync2;
`else
   assign w_sig = signal_in;
`endif

   always_ff @(posedge clk) begin
      r_sig_d <= w_sig;
   end

   assign w_rise = w_sig & ~r_sig_d & ch_enable;
   assign w_hs   = r_ev_valid & ev_ready;

   always_comb begin
      w_dec     = '0;
      w_ovf_set = '0;
      w_pend    = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_dec[i]     = w_hs && (r_ev_ch == IDX_W'(i));
         w_ovf_set[i] = w_rise[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX);
         w_pend[i]    = (r_cnt[i] != '0);
      end
   end

   // A rise coinciding with the accepting handshake cancels out and never overflows.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_rise[i] && !w_dec[i]) begin
               if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (!w_rise[i] && w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
            if (w_ovf_set[i])         r_ovf[i] <= 1'b1;
            else if (overflow_clr[i]) r_ovf[i] <= 1'b0;
         end
      end
   end

   // Ring distance from the slot after the last served channel; smallest pending distance wins.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_best  = N_CH;
      w_dist  = 0;
      for (int j = 0; j < N_CH; j++) begin
         w_dist = (j + N_CH - 1 - int'(r_rr)) % N_CH;
         if (w_pend[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_grant = IDX_W'(j);
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ev_valid <= 1'b0;
         r_ev_ch    <= '0;
         r_rr       <= IDX_W'(N_CH - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_ev_ch    <= w_grant;
                  r_ev_valid <= 1'b1;
                  r_state    <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (w_hs) begin
                  r_rr       <= r_ev_ch;
                  r_ev_valid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ev_valid    = r_ev_valid;
   assign ev_ch       = r_ev_ch;
   assign overflow    = r_ovf;
   assign pending_any = |w_pend;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed bench for sync_event_arbiter (default build, no input synchronizer).
module tb_sync_event_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] signal_in;
  logic [3:0] ch_enable;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [3:0] overflow;
  logic [3:0] overflow_clr;
  logic       pending_any;

  int n_chk  = 0;
  int n_fail = 0;

  int         hs_total = 0;
  logic [1:0] hs_log [0:127];

  sync_event_arbiter #(.N_CH(4), .CNT_W(4), .IDX_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .signal_in    (signal_in),
    .ch_enable    (ch_enable),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_ch        (ev_ch),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .pending_any  (pending_any)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      hs_log[hs_total] = ev_ch;
      hs_total = hs_total + 1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base;
    int ok;
    rst          = 1'b1;
    signal_in    = 4'b0101;
    ch_enable    = 4'b1111;
    ev_ready     = 1'b0;
    overflow_clr = 4'b0000;
    repeat (3) step();
    chk("reset_valid", ev_valid, 1'b0);
    chk("reset_ch", ev_ch, 2'd0);
    chk("reset_ovf", overflow, 4'b0000);
    chk("reset_pend", pending_any, 1'b0);

    // Lines already high at reset release must not create events.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rel_valid", ev_valid, 1'b0);
      chk("rel_pend", pending_any, 1'b0);
    end

    // Single rise on ch2.
    signal_in = 4'b0000;
    ev_ready  = 1'b1;
    step();
    base = hs_total;
    signal_in = 4'b0100;
    step();
    chk("c2_k_valid", ev_valid, 1'b0);
    chk("c2_k_pend", pending_any, 1'b1);
    step();
    chk("c2_k1_valid", ev_valid, 1'b1);
    chk("c2_k1_ch", ev_ch, 2'd2);
    step();
    chk("c2_k2_valid", ev_valid, 1'b0);
    chk("c2_k2_pend", pending_any, 1'b0);
    chk("c2_hs_count", hs_total - base, 1);
    chk("c2_hs_ch", hs_log[base], 2'd2);

    // Fresh pointer, simultaneous rises on 0,1,3.
    rst = 1'b1;
    signal_in = 4'b0000;
    step();
    rst = 1'b0;
    base = hs_total;
    signal_in = 4'b1011;
    step();
    chk("rr_a0_valid", ev_valid, 1'b0);
    step();
    chk("rr_a1_valid", ev_valid, 1'b1);
    chk("rr_a1_ch", ev_ch, 2'd0);
    step();
    chk("rr_a2_valid", ev_valid, 1'b0);
    step();
    chk("rr_a3_valid", ev_valid, 1'b1);
    chk("rr_a3_ch", ev_ch, 2'd1);
    step();
    chk("rr_a4_valid", ev_valid, 1'b0);
    step();
    chk("rr_a5_valid", ev_valid, 1'b1);
    chk("rr_a5_ch", ev_ch, 2'd3);
    step();
    chk("rr_a6_valid", ev_valid, 1'b0);
    chk("rr_a6_pend", pending_any, 1'b0);
    chk("rr_a_count", hs_total - base, 3);

    // Pointer now at 3: ch0 before ch1.
    signal_in = 4'b0000;
    step();
    base = hs_total;
    signal_in = 4'b0011;
    step();
    step();
    chk("rr_b1_ch", ev_ch, 2'd0);
    chk("rr_b1_valid", ev_valid, 1'b1);
    step();
    step();
    chk("rr_b3_ch", ev_ch, 2'd1);
    chk("rr_b3_valid", ev_valid, 1'b1);
    step();
    chk("rr_b_count", hs_total - base, 2);
    chk("rr_b_first", hs_log[base], 2'd0);

    // Saturation on ch1 with the consumer stalled.
    ev_ready  = 1'b0;
    signal_in = 4'b0000;
    step();
    for (int i = 0; i < 17; i++) begin
      signal_in = 4'b0010;
      step();
      signal_in = 4'b0000;
      step();
      if (i == 14) begin
        chk("sat_15_ovf", overflow, 4'b0000);
      end
    end
    chk("sat_ovf", overflow, 4'b0010);
    chk("sat_valid", ev_valid, 1'b1);
    chk("sat_ch", ev_ch, 2'd1);
    base = hs_total;
    ev_ready = 1'b1;
    repeat (40) step();
    chk("sat_count", hs_total - base, 15);
    ok = 1;
    for (int i = 0; i < 15; i++) if (hs_log[base + i] !== 2'd1) ok = 0;
    chk("sat_all_ch1", ok, 1);
    chk("sat_pend", pending_any, 1'b0);
    chk("sat_ovf_sticky", overflow, 4'b0010);
    overflow_clr = 4'b0010;
    step();
    overflow_clr = 4'b0000;
    chk("ovf_clr", overflow, 4'b0000);

    // Rise on ch0 coinciding with the handshake of a ch0 event.
    ev_ready  = 1'b0;
    base      = hs_total;
    signal_in = 4'b0001;
    step();
    signal_in = 4'b0000;
    step();
    chk("coin_present", ev_valid, 1'b1);
    chk("coin_present_ch", ev_ch, 2'd0);
    signal_in = 4'b0001;
    ev_ready  = 1'b1;
    step();
    chk("coin_valid", ev_valid, 1'b0);
    chk("coin_pend", pending_any, 1'b1);
    chk("coin_ovf", overflow, 4'b0000);
    step();
    chk("coin_again_valid", ev_valid, 1'b1);
    chk("coin_again_ch", ev_ch, 2'd0);
    step();
    chk("coin_done_pend", pending_any, 1'b0);
    repeat (4) step();
    chk("coin_count", hs_total - base, 2);

    // Reset while an event is presented and others are queued.
    ev_ready  = 1'b0;
    signal_in = 4'b0000;
    step();
    signal_in = 4'b1110;
    step();
    step();
    chk("mid_valid", ev_valid, 1'b1);
    chk("mid_ch", ev_ch, 2'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", ev_valid, 1'b0);
    chk("mid_rst_pend", pending_any, 1'b0);
    rst      = 1'b0;
    ev_ready = 1'b1;
    base     = hs_total;
    ok       = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ev_valid !== 1'b0) ok = 0;
    end
    chk("mid_quiet", ok, 1);
    chk("mid_count", hs_total - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
